// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl
// -------------
// Control and downstream stage for a pipelined unsigned 32x32 multiplier.
// It takes MULT/MULTU/MTHI/MTLO from the CPU datapath and registers the
// operand magnitudes into the multiplier. It then counts the multiplier
// latency, sign-corrects the 64-bit product for MULT, and commits the result
// to the architectural HI/LO registers. While a multiply is in flight, the
// CPU is stalled on any HI/LO access and on any new HI/LO-writing request.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   op_mult      signed multiply request (rs*rt)
//   op_multu     unsigned multiply request (rs*rt)
//   op_mthi      write rs_data to HI
//   op_mtlo      write rs_data to LO
//   rd_hilo_req  current instruction reads HI or LO
//   rs_data      first operand
//   rt_data      second operand
//   mul_z        64-bit product from the pipelined multiplier
//   mul_a/mul_b  registered multiplier operands (unsigned magnitudes)
//   hi/lo        architectural HI/LO registers
//   busy         multiply in flight
//   stall        hold the issuing instruction
//   done         one-cycle pulse after HI/LO is written by a multiply
module hilo_mul_ctrl #(
  parameter int MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_mult,
  input  logic        op_multu,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic        rd_hilo_req,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [63:0] mul_z,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          neg_reg, neg_next;
  logic [31:0]   mul_a_reg, mul_a_next;
  logic [31:0]   mul_b_reg, mul_b_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;
  logic          done_reg, done_next;

  // Two's-complement magnitudes. |0x80000000| wraps to 0x80000000, which is
  // exactly 2^31 when read as unsigned, so no extra bit is needed.
  logic [31:0] rs_mag, rt_mag;
  assign rs_mag = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
  assign rt_mag = rt_data[31] ? (~rt_data + 32'd1) : rt_data;

  // Sign-corrected product. Negating zero gives zero, and the largest
  // magnitude product (2^62) stays positive, so a plain 64-bit negate is
  // enough.
  logic [63:0] prod_fix;
  assign prod_fix = neg_reg ? (~mul_z + 64'd1) : mul_z;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    neg_next   = neg_reg;
    mul_a_next = mul_a_reg;
    mul_b_next = mul_b_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (op_mult) begin
          mul_a_next = rs_mag;
          mul_b_next = rt_mag;
          neg_next   = rs_data[31] ^ rt_data[31];
          cnt_next   = CW'(MUL_LAT);
          state_next = S_WAIT;
        end else if (op_multu) begin
          mul_a_next = rs_data;
          mul_b_next = rt_data;
          neg_next   = 1'b0;
          cnt_next   = CW'(MUL_LAT);
          state_next = S_WAIT;
        end else begin
          // MTHI and MTLO may arrive together; both take rs_data.
          if (op_mthi) hi_next = rs_data;
          if (op_mtlo) lo_next = rs_data;
        end
      end

      S_WAIT: begin
        // Operands stay put so the multiplier pipeline sees stable inputs.
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CW'(1);
        end else begin
          hi_next    = prod_fix[63:32];
          lo_next    = prod_fix[31:0];
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      neg_reg   <= 1'b0;
      mul_a_reg <= '0;
      mul_b_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      neg_reg   <= neg_next;
      mul_a_reg <= mul_a_next;
      mul_b_reg <= mul_b_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
    end
  end

  assign busy  = (state_reg == S_WAIT);
  assign stall = busy & (rd_hilo_req | op_mult | op_multu | op_mthi | op_mtlo);
  assign mul_a = mul_a_reg;
  assign mul_b = mul_b_reg;
  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
module tb_hilo_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_mult, op_multu, op_mthi, op_mtlo, rd_hilo_req;
  logic [31:0] rs_data, rt_data;
  logic [63:0] mul_z;
  logic [31:0] mul_a, mul_b, hi, lo;
  logic        busy, stall, done;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_mul_ctrl #(.MUL_LAT(5)) dut (
    .clk(clk), .reset(reset),
    .op_mult(op_mult), .op_multu(op_multu), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
    .rd_hilo_req(rd_hilo_req), .rs_data(rs_data), .rt_data(rt_data), .mul_z(mul_z),
    .mul_a(mul_a), .mul_b(mul_b), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  // Five-stage unsigned multiplier, cleared by the shared reset.
  logic [63:0] pipe [0:4];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) pipe[i] <= 64'd0;
    end else begin
      pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
      for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mul_z = pipe[4];

  // Reference: architectural result of MULT/MULTU.
  function automatic logic [63:0] ref_prod(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Reference: operand as fed to the unsigned multiplier.
  function automatic logic [31:0] ref_mag(input bit sgn, input logic [31:0] a);
    longint la;
    if (!sgn) return a;
    la = longint'($signed(a));
    if (la < 0) la = -la;
    return la[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply from IDLE and follow it to completion.
  task automatic do_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_rd, input bit with_mthi);
    logic [63:0] exp_p;
    logic [31:0] hi_before;
    int cycles, dones, stalls;
    exp_p     = ref_prod(sgn, a, b);
    hi_before = hi;
    op_mult   = sgn;
    op_multu  = !sgn;
    op_mthi   = with_mthi;
    rs_data   = a;
    rt_data   = b;
    tick();
    op_mult = 0; op_multu = 0; op_mthi = 0;
    rs_data = $urandom; rt_data = $urandom;
    rd_hilo_req = hold_rd;
    chk("accept_busy", 64'(busy), 64'd1);
    chk("mul_a", 64'(mul_a), 64'(ref_mag(sgn, a)));
    chk("mul_b", 64'(mul_b), 64'(ref_mag(sgn, b)));
    if (with_mthi) chk("mthi_ignored", 64'(hi), 64'(hi_before));
    cycles = 0; dones = 0; stalls = 0;
    while (busy && cycles < 20) begin
      if (stall) stalls++;
      if (done) dones++;
      tick();
      cycles++;
    end
    chk("busy_cycles", 64'(cycles), 64'd6);
    chk("done_in_busy", 64'(dones), 64'd0);
    chk("hilo", {hi, lo}, exp_p);
    chk("done_pulse", 64'(done), 64'd1);
    chk("mul_a_held", 64'(mul_a), 64'(ref_mag(sgn, a)));
    if (hold_rd) begin
      chk("stall_cycles", 64'(stalls), 64'd6);
      chk("stall_drop", 64'(stall), 64'd0);
    end
    rd_hilo_req = 0;
    tick();
    chk("done_clear", 64'(done), 64'd0);
    $display("[TB] %s %08h*%08h -> %016h (%0d busy cycles)", sgn ? "MULT " : "MULTU", a, b, {hi, lo}, cycles);
  endtask

  initial begin
    logic [31:0] corners [0:5];
    int cycles, dones;
    bit sgn;
    logic [31:0] a, b;

    corners[0] = 32'h00000000; corners[1] = 32'h00000001; corners[2] = 32'hFFFFFFFF;
    corners[3] = 32'h80000000; corners[4] = 32'h7FFFFFFF; corners[5] = 32'h00010000;

    reset = 1; op_mult = 0; op_multu = 0; op_mthi = 0; op_mtlo = 0;
    rd_hilo_req = 0; rs_data = 0; rt_data = 0;
    repeat (3) tick();
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_mul", {mul_a, mul_b}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 0;
    tick();

    // Test plan directed cases
    do_mul(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    chk("plan_multu_hi", 64'(hi), 64'h0FFFFFFFE);
    chk("plan_multu_lo", 64'(lo), 64'h000000001);
    do_mul(1, 32'hFFFFFFFF, 32'h00000002, 0, 0);
    chk("plan_mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    do_mul(1, 32'h80000000, 32'h80000000, 0, 0);
    chk("plan_min_sq", {hi, lo}, 64'h40000000_00000000);
    do_mul(1, 32'h80000000, 32'h00000001, 0, 0);
    chk("plan_min_one", {hi, lo}, 64'hFFFFFFFF_80000000);
    do_mul(1, 32'h00000000, 32'hFFFFFFFF, 0, 0);
    chk("plan_neg_zero", {hi, lo}, 64'd0);
    do_mul(1, 32'hFFFFFFF9, 32'h00000003, 1, 0);   // MFHI held during the multiply
    do_mul(1, 32'h00000011, 32'hFFFFFFFE, 0, 1);   // MULT plus MTHI together

    // MTHI+MTLO in IDLE, then MTHI alone; reads in IDLE never stall
    op_mthi = 1; op_mtlo = 1; rs_data = 32'h00001234; rd_hilo_req = 1;
    #1 chk("idle_no_stall", 64'(stall), 64'd0);
    tick();
    op_mthi = 0; op_mtlo = 0; rd_hilo_req = 0;
    chk("mthi_mtlo", {hi, lo}, {32'h00001234, 32'h00001234});
    chk("mt_no_done", 64'(done), 64'd0);
    chk("mt_no_busy", 64'(busy), 64'd0);
    op_mthi = 1; rs_data = 32'hAAAA0000;
    tick();
    op_mthi = 0;
    chk("mthi_only", {hi, lo}, {32'hAAAA0000, 32'h00001234});
    $display("[TB] MTHI/MTLO -> hi=%08h lo=%08h", hi, lo);

    // MULTU issued during WAIT is held off, then accepted from IDLE
    op_mult = 1; rs_data = 32'd3; rt_data = 32'd5;
    tick();
    op_mult = 0; op_multu = 1; rs_data = 32'd7; rt_data = 32'd9;
    cycles = 0;
    while (busy && cycles < 20) begin
      chk("ovl_stall", 64'(stall), 64'd1);
      chk("ovl_operand", {mul_a, mul_b}, {32'd3, 32'd5});
      tick();
      cycles++;
    end
    chk("ovl_cycles", 64'(cycles), 64'd6);
    chk("ovl_first", {hi, lo}, ref_prod(1, 32'd3, 32'd5));
    chk("ovl_idle_stall", 64'(stall), 64'd0);
    tick();
    op_multu = 0;
    chk("ovl_accept", {mul_a, mul_b}, {32'd7, 32'd9});
    chk("ovl_busy", 64'(busy), 64'd1);
    cycles = 0;
    while (busy && cycles < 20) begin tick(); cycles++; end
    chk("ovl_cycles2", 64'(cycles), 64'd6);
    chk("ovl_second", {hi, lo}, ref_prod(0, 32'd7, 32'd9));
    $display("[TB] overlap MULTU -> %016h", {hi, lo});
    tick();

    // Randomized multiplies against the reference model
    for (int k = 0; k < 24; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      do_mul(sgn, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset during the third WAIT cycle aborts the multiply
    op_multu = 1; rs_data = 32'h12345678; rt_data = 32'h9ABCDEF0;
    tick();
    op_multu = 0;
    tick();
    tick();
    reset = 1;
    tick();
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_mul", {mul_a, mul_b}, 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    reset = 0;
    dones = (done === 1'b1) ? 1 : 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_hilo_kept", {hi, lo}, 64'd0);
    $display("[TB] reset in WAIT -> hi=%08h lo=%08h busy=%0b", hi, lo, busy);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_mul_ctrl.md
Name: hilo_mul_ctrl

Overview:
- Downstream and control stage for the 5-stage pipelined unsigned 32x32 multiplier.
- Accepts MULT/MULTU/MTHI/MTLO from the CPU datapath and feeds magnitude operands to the multiplier.
- Counts the multiplier latency, sign-corrects the 64-bit product for MULT, and commits it to the architectural HI/LO registers.
- Stalls the CPU on HI/LO reads or writes while a multiply is in flight.

Parameters:
- MUL_LAT, 5, clock edges from the multiplier sampling its operands to its product being valid on its output.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- op_mult  in  1  signed multiply request, rs*rt.
- op_multu  in  1  unsigned multiply request, rs*rt.
- op_mthi  in  1  write rs_data to HI.
- op_mtlo  in  1  write rs_data to LO.
- rd_hilo_req  in  1  current instruction reads HI or LO (MFHI/MFLO).
- rs_data  in  32  first operand.
- rt_data  in  32  second operand.
- mul_z  in  64  product from the pipelined multiplier.
- mul_a  out  32  multiplier operand A, registered.
- mul_b  out  32  multiplier operand B, registered.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  multiply in flight.
- stall  out  1  hold the issuing instruction.
- done  out  1  one-cycle pulse after HI/LO is written by a multiply.

Behaviour:
- Reset values: hi=0, lo=0, mul_a=0, mul_b=0, busy=0, done=0, state=IDLE, cnt=0, neg=0. The reset is shared with the multiplier, so its pipeline is cleared at the same time.
- States: IDLE and WAIT. busy = (state==WAIT).
- stall = busy & (rd_hilo_req | op_mult | op_multu | op_mthi | op_mtlo). Combinational. stall=0 in IDLE.
- Accept (IDLE, op_mult|op_multu, edge E0):
  - MULTU: mul_a<=rs, mul_b<=rt, neg<=0.
  - MULT: mul_a<=|rs|, mul_b<=|rt| as 32-bit unsigned magnitudes (|0x80000000| = 0x80000000); neg<=rs[31]^rt[31].
  - Load cnt<=MUL_LAT; state<=WAIT.
- WAIT:
  - Each edge with cnt!=0: cnt<=cnt-1.
  - Edge with cnt==0 (E0+MUL_LAT+1 = E6 by default): hi:lo <= neg ? (~mul_z+1) : mul_z, all 64 bits; state<=IDLE; done<=1 for exactly one cycle.
  - mul_a/mul_b are held stable throughout WAIT.
- Latency: busy is high for MUL_LAT+1 cycles. New HI/LO is visible the cycle busy falls. A dependent MFHI/MFLO stalls until then.
- Priority in IDLE: op_mult > op_multu > (op_mthi, op_mtlo).
  - When a multiply is accepted, a coincident MTHI/MTLO is ignored.
  - MTHI and MTLO together both write rs_data on the same edge.
- Requests arriving during WAIT are not accepted; stall holds them for the CPU to reissue. A multiply is never restarted or overlapped.
- rd_hilo_req in IDLE: no stall; hi/lo present current values combinationally.
- Sign correction: negating a zero product yields 0. The -2^31 * -2^31 case gives +2^62 with no overflow.
- Reset in WAIT: aborts immediately; no HI/LO write and no done pulse.
- mul_z is ignored except on the commit edge.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> mul_a=mul_b=0xFFFFFFFF; busy high 6 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT rs=0xFFFFFFFF (-1), rt=0x00000002 -> mul_a=1, mul_b=2; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Signed MULT cases:
  - rs=rt=0x80000000 -> hi=0x40000000, lo=0.
  - rs=0x80000000, rt=1 -> hi=0xFFFFFFFF, lo=0x80000000.
  - rs=0, rt=0xFFFFFFFF -> hi=lo=0.
- Stall behaviour:
  - rd_hilo_req held from the cycle after accept -> stall=1 for 6 cycles, drops with busy, and hi/lo already hold the new product.
  - MULTU issued during WAIT -> stall=1, operands unchanged, accepted only after return to IDLE.
- MTHI/MTLO in IDLE with rs=0x00001234 -> hi=lo=0x00001234 next edge, done=0.
- MULT plus MTHI same cycle -> only the multiply takes effect.
- Reset asserted on the 3rd WAIT cycle -> next edge hi=lo=0, busy=0, mul_a=mul_b=0, no done pulse ever.
